// File: rtl/alu_pkg.sv
// Shared encodings for the sequential multiply/divide unit and its ALU:
// ALU operation codes, FSM state encoding and request op encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Counter value during the final shift/add or shift/subtract step.
  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULU = 1'b0,
    OP_DIVU = 1'b1
  } op_t;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// 32-bit combinational ALU: and/or/add/subtract/set-less-than.
// cout is the adder carry; on subtract it is 1 when there is no borrow (a >= b).
module ALU_32
  import alu_pkg::*;
(
  input  logic [3:0]  i_alu_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_cout
);

  logic        w_sub;
  logic [32:0] w_sum;

  // Subtraction is a + ~b with carry-in 1, so cout doubles as "no borrow".
  assign w_sub = (i_alu_op == ALU_SUB) || (i_alu_op == ALU_SLT);
  assign w_sum = {1'b0, i_a} + {1'b0, (w_sub ? ~i_b : i_b)} + {32'b0, w_sub};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_result = '0;
    o_cout   = 1'b0;
    case (i_alu_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD,
      ALU_SUB: begin
        o_result = w_sum[31:0];
        o_cout   = w_sum[32];
      end
      ALU_SLT: o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned 32x32 multiply (shift/add) and divide (restoring,
// shift/subtract), 32 iterations through a single shared ALU.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [3:0]       w_alu_op;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_cout;
  logic [WIDTH-1:0] w_r;
  logic             w_last;
  logic             w_div_zero;

  assign w_r        = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_last     = (r_cnt == LAST_ITER);
  assign w_div_zero = (op_t'(op) == OP_DIVU) && (b == '0);
  assign w_alu_op   = (r_state == ST_DIV) ? ALU_SUB : ALU_ADD;
  assign w_alu_a    = (r_state == ST_DIV) ? w_r : r_hi;

  ALU_32 u_alu (
    .i_alu_op (w_alu_op),
    .i_a      (w_alu_a),
    .i_b      (r_b),
    .o_result (w_alu_res),
    .o_cout   (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (op_t'(op) == OP_MULU) w_state_nxt = ST_MUL;
          else if (w_div_zero)      w_state_nxt = ST_DONE;
          else                      w_state_nxt = ST_DIV;
        end
      end
      ST_MUL,
      ST_DIV:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The requested op is carried by the state (MUL vs DIV); a lives in lo.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_b   <= b;
            r_cnt <= '0;
            if (w_div_zero) begin
              r_hi <= a;
              r_lo <= '1;
              r_dz <= 1'b1;
            end else begin
              r_hi <= '0;
              r_lo <= a;
              r_dz <= 1'b0;
            end
          end
        end
        ST_MUL: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_lo[0]) {r_hi, r_lo} <= {w_cout, w_alu_res, r_lo[WIDTH-1:1]};
          else         {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
        end
        ST_DIV: begin
          r_cnt <= r_cnt + 6'd1;
          // hi[31] set means the shifted remainder has a 33rd bit and always exceeds b.
          if (r_hi[WIDTH-1] || w_cout) begin
            r_hi <= w_alu_res;
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_r;
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
      r_busy <= (w_state_nxt == ST_MUL) || (w_state_nxt == ST_DIV);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: timing, products, quotients/remainders,
// divide-by-zero, held start and mid-operation reset.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns one falling edge after the
  // accepting rising edge k (i.e. in cycle k+1). start is left high.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge clk);
  endtask

  // Called in cycle k+1; returns in the cycle where done is seen.
  task automatic wait_done(input string tag, input int exp_lat);
    int n  = 1;
    int nb = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_lat - 1));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULU 3*5
    issue(1'b0, 32'd3, 32'd5);
    start = 1'b0;
    check("mul3x5_busy_k1", 32'(busy), 32'd1);
    wait_done("mul3x5", 33);
    check("mul3x5_hi", hi, 32'd0);
    check("mul3x5_lo", lo, 32'd15);
    check("mul3x5_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    check("mul3x5_done_pulse", 32'(done), 32'd0);
    check("mul3x5_lo_hold", lo, 32'd15);

    // MULU max*max
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start = 1'b0;
    wait_done("mulmax", 33);
    check("mulmax_hi", hi, 32'hFFFF_FFFE);
    check("mulmax_lo", lo, 32'h0000_0001);
    @(negedge clk);

    // DIVU 100/7
    issue(1'b1, 32'd100, 32'd7);
    start = 1'b0;
    wait_done("div100", 33);
    check("div100_lo", lo, 32'd14);
    check("div100_hi", hi, 32'd2);
    check("div100_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);

    // DIVU with divisor having the top bit set
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    start = 1'b0;
    wait_done("divbig", 33);
    check("divbig_lo", lo, 32'd1);
    check("divbig_hi", hi, 32'h7FFF_FFFE);
    @(negedge clk);

    // DIVU by zero: done immediately after the accepting edge
    issue(1'b1, 32'd5, 32'd0);
    start = 1'b0;
    wait_done("div0", 1);
    check("div0_dz", 32'(div_by_zero), 32'd1);
    check("div0_hi", hi, 32'd5);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    @(negedge clk);
    check("div0_done_pulse", 32'(done), 32'd0);
    check("div0_dz_hold", 32'(div_by_zero), 32'd1);
    check("div0_hi_hold", hi, 32'd5);
    issue(1'b0, 32'd3, 32'd5);
    start = 1'b0;
    check("div0_dz_cleared", 32'(div_by_zero), 32'd0);
    wait_done("after_div0", 33);
    check("after_div0_lo", lo, 32'd15);
    @(negedge clk);

    // start held high through MULU 2*3, then a second request with new operands
    issue(1'b0, 32'd2, 32'd3);
    wait_done("hold1", 33);
    check("hold1_lo", lo, 32'd6);
    check("hold1_hi", hi, 32'd0);
    a = 32'd4;
    b = 32'd5;
    @(negedge clk);
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    check("hold2_busy", 32'(busy), 32'd1);
    check("hold2_lo_init", lo, 32'd4);
    start = 1'b0;
    wait_done("hold2", 33);
    check("hold2_lo", lo, 32'd20);
    check("hold2_hi", hi, 32'd0);
    @(negedge clk);

    // reset at iteration 10 aborts the request
    issue(1'b0, 32'd7, 32'd9);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
